// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the iterative MULT/DIV engine: state encoding and op codes.
// The Control_Unit wait state imports the same package.
package muldiv_defs;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 6;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: a radix-2 Booth step for MULT or a restoring-divide
// step on magnitudes for DIV. Purely combinational; the sequencer owns the registers.
module muldiv_step
  import muldiv_defs::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              op_i,
  input  logic [DATA_W-1:0] hi_i,    // Booth partial product high / remainder
  input  logic [DATA_W-1:0] lo_i,    // multiplier being scanned / dividend-quotient
  input  logic              q_m1_i,
  input  logic [DATA_W-1:0] aux_i,   // multiplicand / divisor magnitude
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              q_m1_o
);

  logic [DATA_W:0] booth_sum;
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // NOTE: every combinational output gets a default before any branch, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    hi_o   = hi_i;
    lo_o   = lo_i;
    q_m1_o = q_m1_i;

    // One guard bit keeps hi +/- multiplicand exact before the arithmetic shift.
    booth_sum = {hi_i[DATA_W-1], hi_i};
    unique case ({lo_i[0], q_m1_i})
      2'b01:   booth_sum = {hi_i[DATA_W-1], hi_i} + {aux_i[DATA_W-1], aux_i};
      2'b10:   booth_sum = {hi_i[DATA_W-1], hi_i} - {aux_i[DATA_W-1], aux_i};
      default: booth_sum = {hi_i[DATA_W-1], hi_i};
    endcase

    shifted = {hi_i, lo_i[DATA_W-1]};
    diff    = shifted - {1'b0, aux_i};

    if (op_i == OP_MULT) begin
      hi_o   = booth_sum[DATA_W:1];
      lo_o   = {booth_sum[0], lo_i[DATA_W-1:1]};
      q_m1_o = lo_i[0];
    end else if (!diff[DATA_W]) begin
      hi_o = diff[DATA_W-1:0];
      lo_o = {lo_i[DATA_W-2:0], 1'b1};
    end else begin
      hi_o = shifted[DATA_W-1:0];
      lo_o = {lo_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Signed MULT/DIV sequencer: IDLE -> INIT -> RUN -> FIX -> DONE, with a registered
// output stage that presents Done/strobes/results one cycle after the DONE state.
module muldiv_sequencer
  import muldiv_defs::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Op,
  input  logic [DATA_W-1:0] Src_A,
  input  logic [DATA_W-1:0] Src_B,
  output logic              Busy,
  output logic              Done,
  output logic              Div_Zero,
  output logic              HI_Write,
  output logic              LO_Write,
  output logic [DATA_W-1:0] HI_Out,
  output logic [DATA_W-1:0] LO_Out
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                op_q, op_d, err_q, err_d;
  logic                sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d, aux_q, aux_d;
  logic                q_m1_q, q_m1_d;
  logic                busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d, wr_q, wr_d;
  logic [DATA_W-1:0]   hi_out_q, hi_out_d, lo_out_q, lo_out_d;
  logic [DATA_W-1:0]   hi_step, lo_step;
  logic                q_m1_step;

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .op_i   (op_q),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .q_m1_i (q_m1_q),
    .aux_i  (aux_q),
    .hi_o   (hi_step),
    .lo_o   (lo_step),
    .q_m1_o (q_m1_step)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    err_d      = err_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    aux_d      = aux_q;
    q_m1_d     = q_m1_q;
    busy_d     = busy_q;
    hi_out_d   = hi_out_q;
    lo_out_d   = lo_out_q;

    // Busy spans the Done cycle, so a Start during that cycle is not accepted.
    if (done_q) busy_d = 1'b0;

    unique case (state_q)
      S_IDLE: if (Start && !busy_q) begin
        op_d    = Op;
        lo_d    = Src_A;
        aux_d   = Src_B;
        busy_d  = 1'b1;
        state_d = S_INIT;
      end
      S_INIT: begin
        hi_d    = '0;
        q_m1_d  = 1'b0;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = S_RUN;
        if (op_q == OP_DIV) begin
          if (aux_q == '0) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            sign_a_d = lo_q[DATA_W-1];
            sign_b_d = aux_q[DATA_W-1];
            if (lo_q[DATA_W-1])  lo_d  = -lo_q;
            if (aux_q[DATA_W-1]) aux_d = -aux_q;
          end
        end
      end
      S_RUN: begin
        hi_d   = hi_step;
        lo_d   = lo_step;
        q_m1_d = q_m1_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        // Truncating division: quotient sign is the XOR, remainder follows the dividend.
        if (op_q == OP_DIV) begin
          if (sign_a_q ^ sign_b_q) lo_d = -lo_q;
          if (sign_a_q)            hi_d = -hi_q;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    done_d     = (state_q == S_DONE);
    div_zero_d = done_d && err_q;
    wr_d       = done_d && !err_q;
    if (wr_d) begin
      hi_out_d = hi_q;
      lo_out_d = lo_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge Clock) begin
    // NOTE: reset is synchronous and clears every register, including the datapath,
    // so a mid-operation reset leaves no stale Done or write strobe behind.
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MULT;
      err_q      <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      aux_q      <= '0;
      q_m1_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      wr_q       <= 1'b0;
      hi_out_q   <= '0;
      lo_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      err_q      <= err_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      aux_q      <= aux_d;
      q_m1_q     <= q_m1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      wr_q       <= wr_d;
      hi_out_q   <= hi_out_d;
      lo_out_q   <= lo_out_d;
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Div_Zero = div_zero_q;
  assign HI_Write = wr_q;
  assign LO_Write = wr_q;
  assign HI_Out   = hi_out_q;
  assign LO_Out   = lo_out_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected results computed with
// 64-bit integer arithmetic; a negedge monitor pops and compares on every Done pulse.
module tb_muldiv_sequencer;

  logic        Clock = 1'b0;
  logic        Reset, Start, Op;
  logic [31:0] Src_A, Src_B;
  logic        Busy, Done, Div_Zero, HI_Write, LO_Write;
  logic [31:0] HI_Out, LO_Out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_events = 0;
  logic        prev_done = 1'b0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  muldiv_sequencer dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Op       (Op),
    .Src_A    (Src_A),
    .Src_B    (Src_B),
    .Busy     (Busy),
    .Done     (Done),
    .Div_Zero (Div_Zero),
    .HI_Write (HI_Write),
    .LO_Write (LO_Write),
    .HI_Out   (HI_Out),
    .LO_Out   (LO_Out)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: signed 64-bit product, or truncating quotient/remainder.
  task automatic model(input logic op, input logic [31:0] a, input logic [31:0] b, output exp_t e);
    longint sa, sb_v, p, q, r;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    e.dz = 1'b0;
    if (op == 1'b0) begin
      p    = sa * sb_v;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.dz = 1'b1;
      e.hi = last_hi;
      e.lo = last_lo;
    end else begin
      q    = sa / sb_v;
      r    = sa % sb_v;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  // Drives a one-cycle Start; the accepting edge is the next posedge (cyc + 1).
  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge Clock);
    Start = 1'b1;
    Op    = op;
    Src_A = a;
    Src_B = b;
    model(op, a, b, e);
    e.due = cyc + 1 + (e.dz ? 2 : 35);
    sb.push_back(e);
    @(negedge Clock);
    Start = 1'b0;
    Op    = 1'($urandom);
    Src_A = $urandom;
    Src_B = $urandom;
  endtask

  task automatic wait_done();
    logic seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge Clock);
      if (Done) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic run(input logic op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b);
    wait_done();
  endtask

  always @(negedge Clock) begin
    if (!Reset) begin
      if (Done) begin
        done_events++;
        check("done_pulse_width", 64'(prev_done), 64'd0);
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("latency_cycle", 64'(cyc), 64'(e.due));
          check("hi_out", 64'(HI_Out), 64'(e.hi));
          check("lo_out", 64'(LO_Out), 64'(e.lo));
          check("div_zero", 64'(Div_Zero), 64'(e.dz));
          check("hi_write", 64'(HI_Write), 64'(!e.dz));
          check("lo_write", 64'(LO_Write), 64'(!e.dz));
          check("busy_with_done", 64'(Busy), 64'd1);
        end
      end else if (HI_Write || LO_Write || Div_Zero) begin
        check("strobe_without_done", {62'd0, HI_Write | LO_Write, Div_Zero}, 64'd0);
      end
    end
    prev_done = Done;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] corner [6];
    corner = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd1, 32'hFFFF_FFFE};

    Reset = 1'b1; Start = 1'b0; Op = 1'b0; Src_A = '0; Src_B = '0;
    repeat (3) @(negedge Clock);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    check("reset_strobes", {61'd0, Div_Zero, HI_Write, LO_Write}, 64'd0);
    check("reset_hi_lo", {HI_Out, LO_Out}, 64'd0);
    Reset = 1'b0;

    run(1'b0, 32'd7, 32'hFFFF_FFFD);
    run(1'b1, 32'hFFFF_FFF9, 32'd2);
    run(1'b1, 32'd7, 32'hFFFF_FFFE);
    run(1'b1, 32'd5, 32'd0);
    run(1'b0, 32'h8000_0000, 32'h8000_0000);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

    // Start re-pulsed mid-operation and held through the Done cycle: all ignored.
    issue(1'b0, 32'h0123_4567, 32'hFFFF_FFA7);
    repeat (4) @(negedge Clock);
    Start = 1'b1; Op = 1'b1; Src_A = 32'd99; Src_B = 32'd0;
    wait_done();
    @(posedge Clock);
    #1 Start = 1'b0;
    @(negedge Clock);
    check("busy_after_done_start", 64'(Busy), 64'd0);

    // Reset mid-operation.
    issue(1'b0, 32'd55, 32'd66);
    repeat (9) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check("midreset_busy", 64'(Busy), 64'd0);
    check("midreset_done", 64'(Done), 64'd0);
    check("midreset_hi_lo", {HI_Out, LO_Out}, 64'd0);
    sb.delete();
    last_hi = '0;
    last_lo = '0;
    Reset = 1'b0;
    done_events = 0;
    repeat (40) @(negedge Clock);
    check("no_done_after_reset", 64'(done_events), 64'd0);
    run(1'b0, 32'd3, 32'd4);

    for (int i = 0; i < 30; i++) begin
      logic        op;
      logic [31:0] a, b;
      op = 1'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(1, 31);
      run(op, a, b);
    end

    repeat (3) @(negedge Clock);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
